seg7_scan_driver: RTL

- Downstream consumer of the CYBERcobra core's 32-bit `out_o` result bus.
- Shows the value as 8 hexadecimal digits on the board's multiplexed, common-anode 7-segment display.
- Time-multiplexes the digits from a programmable prescaler.
- Latches the value once per frame so a digit never changes part-way through a scan.
- Optionally blanks leading zeros.

---
 rtl/seg7_scan_driver.sv | 104 ++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Scans a 32-bit value onto an 8-digit common-anode 7-segment display as hex,
// one digit per CLK_DIV clocks, with per-frame latching and optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] value_i,
  input  logic        en_i,
  input  logic        blank_i,
  output logic [7:0]  an_o,
  output logic [6:0]  seg_o,
  output logic        dp_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic {BLANK, SCAN} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   shd;

  logic          tick;
  logic [2:0]    idx_n;
  logic [31:0]   shd_n;
  logic [31:0]   upper_n;
  logic [3:0]    nib_n;
  logic          blanked_n;
  logic [7:0]    an_n;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      default: code = 7'h0E;
    endcase
    return code;
  endfunction

  // Outputs are built from the post-edge idx/shd so a slot and its digit change together.
  always_comb begin
    tick      = en_i && (cnt == CNT_MAX);
    idx_n     = tick ? idx + 3'd1 : idx;
    shd_n     = (tick && (idx == 3'd7)) ? value_i : shd;
    upper_n   = shd_n >> {idx_n, 2'b00};
    nib_n     = upper_n[3:0];
    blanked_n = blank_i && (idx_n != 3'd0) && (upper_n == 32'd0);
    an_n      = blanked_n ? 8'hFF : ~(8'd1 << idx_n);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= 3'd7;
      shd   <= 32'd0;
      an_o  <= 8'hFF;
      seg_o <= 7'h7F;
    end else begin
      if (en_i) begin
        cnt <= tick ? '0 : cnt + 1'b1;
      end
      idx <= idx_n;
      shd <= shd_n;
      case (state)
        BLANK: begin
          if (tick) begin
            state <= SCAN;
            an_o  <= an_n;
            seg_o <= hex_decode(nib_n);
          end
        end
        SCAN: begin
          if (!en_i) begin
            an_o <= 8'hFF;
          end else begin
            an_o  <= an_n;
            seg_o <= hex_decode(nib_n);
          end
        end
      endcase
    end
  end

  assign dp_o = 1'b1;

endmodule
